// File: rtl/musa_pkg.sv
// -----------------------------------------------------------------------------
// musa_pkg
// Shared constants and types for the hardware stack.
//   WORD_WIDTH  : default data word width
//   STACK_DEPTH : default number of stack entries
//   stack_state_t : stack controller FSM state encoding
//   sp_width()  : width of an entry counter able to hold 0..depth
// -----------------------------------------------------------------------------
package musa_pkg;

  localparam int WORD_WIDTH  = 32;
  localparam int STACK_DEPTH = 16;

  // One bit is enough for two states. READ = 1 lets busy come straight off
  // the state flop.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_READ = 1'b1
  } stack_state_t;

  // An entry count must reach DEPTH itself, so it needs one bit more than
  // the RAM address.
  function automatic int sp_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage : musa_pkg

// File: rtl/stack_ram.sv
// -----------------------------------------------------------------------------
// stack_ram
// Simple dual-port storage for the stack: one synchronous write port and one
// synchronous read port with a single cycle of read latency. Written so that
// synthesis infers block RAM. The contents are deliberately not reset.
//
// Ports
//   clk     : clock, all activity on rising edge
//   wr_en   : write enable
//   wr_addr : write address
//   wr_data : write data
//   rd_en   : read enable; rd_data updates on the edge that samples it
//   rd_addr : read address
//   rd_data : registered read data, holds between reads
// -----------------------------------------------------------------------------
module stack_ram
  import musa_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH,
  parameter int DEPTH = STACK_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [WIDTH-1:0] rd_data_reg;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_reg[wr_addr] <= wr_data;
    end
  end

  // Registered read, no reset, so the read register folds into the RAM
  // primitive's output register.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data_reg <= mem_reg[rd_addr];
    end
  end

  assign rd_data = rd_data_reg;

endmodule : stack_ram

// File: rtl/stack_unit.sv
// -----------------------------------------------------------------------------
// stack_unit
// Hardware LIFO stack fed by the decode stage. A push completes in one cycle.
// A pop takes two cycles: the request edge launches the RAM read, and the
// next edge registers the RAM output into pop_data and raises pop_valid for
// one cycle. Misuse (overflow, underflow, protocol errors) is dropped and
// recorded in sticky flags.
//
// Ports
//   clk        : clock, all state updates on its rising edge
//   rst        : asynchronous active-low reset
//   push_in    : one-cycle push request
//   pop_in     : one-cycle pop request
//   push_data  : word to push
//   flush      : empty the stack (sp -> 0)
//   clr_err    : clear sticky error flags
//   pop_data   : popped word, valid while pop_valid is high, held otherwise
//   pop_valid  : one-cycle pulse marking pop_data valid
//   busy       : high while a pop read is in flight
//   full       : sp == DEPTH (combinational)
//   empty      : sp == 0 (combinational)
//   sp         : current entry count, 0..DEPTH
//   overflow   : sticky, push attempted while full
//   underflow  : sticky, pop attempted while empty
//   proto_err  : sticky, push+pop together, or a request during a pop read
// -----------------------------------------------------------------------------
module stack_unit
  import musa_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH,
  parameter int DEPTH = STACK_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_in,
  input  logic                       pop_in,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       flush,
  input  logic                       clr_err,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       pop_valid,
  output logic                       busy,
  output logic                       full,
  output logic                       empty,
  output logic [sp_width(DEPTH)-1:0] sp,
  output logic                       overflow,
  output logic                       underflow,
  output logic                       proto_err
);

  localparam int SPW = sp_width(DEPTH);
  localparam int AW  = SPW - 1;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  stack_state_t     state_reg, state_next;
  logic [SPW-1:0]   sp_reg, sp_next;
  logic [WIDTH-1:0] pop_data_reg;
  logic             pop_valid_reg, pop_valid_next;
  logic             overflow_reg, overflow_next;
  logic             underflow_reg, underflow_next;
  logic             proto_err_reg, proto_err_next;

  // Control strobes from the output decode
  logic             ram_we;
  logic             ram_re;
  logic             set_overflow;
  logic             set_underflow;
  logic             set_proto;

  // RAM hookup
  logic [AW-1:0]    ram_waddr;
  logic [AW-1:0]    ram_raddr;
  logic [WIDTH-1:0] ram_rdata;

  // Status derived from the entry count
  logic             full_w;
  logic             empty_w;
  logic             pop_accept;

  assign full_w  = (sp_reg == SPW'(DEPTH));
  assign empty_w = (sp_reg == '0);

  // A pop is taken only as a clean single request in IDLE with data present.
  // Flush wins over any coincident request.
  assign pop_accept = (state_reg == ST_IDLE) && !flush && pop_in && !push_in
                      && !empty_w;

  // Push writes the slot just above the top; pop reads the top slot.
  // Neither address is used at the boundary where it would not fit,
  // because full blocks the push and empty blocks the pop.
  assign ram_waddr = AW'(sp_reg);
  assign ram_raddr = AW'(sp_reg - SPW'(1));

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  stack_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_stack_ram (
    .clk     (clk),
    .wr_en   (ram_we),
    .wr_addr (ram_waddr),
    .wr_data (push_data),
    .rd_en   (ram_re),
    .rd_addr (ram_raddr),
    .rd_data (ram_rdata)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (pop_accept) begin
          state_next = ST_READ;
        end
      end
      ST_READ: begin
        // The read is always exactly one cycle, so leave unconditionally.
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output / control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    sp_next        = sp_reg;
    ram_we         = 1'b0;
    ram_re         = 1'b0;
    pop_valid_next = 1'b0;
    set_overflow   = 1'b0;
    set_underflow  = 1'b0;
    set_proto      = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (flush) begin
          // Coincident push/pop is silently discarded.
          sp_next = '0;
        end else if (push_in && pop_in) begin
          set_proto = 1'b1;
        end else if (push_in) begin
          if (full_w) begin
            set_overflow = 1'b1;
          end else begin
            ram_we  = 1'b1;
            sp_next = sp_reg + SPW'(1);
          end
        end else if (pop_in) begin
          if (empty_w) begin
            set_underflow = 1'b1;
          end else begin
            ram_re  = 1'b1;
            sp_next = sp_reg - SPW'(1);
          end
        end
      end

      ST_READ: begin
        // The RAM already holds the popped word on its output, so the pop
        // completes this cycle regardless of flush; a flush here simply
        // zeroes the count as the pop retires.
        pop_valid_next = 1'b1;
        if (flush) begin
          sp_next = '0;
        end else if (push_in || pop_in) begin
          set_proto = 1'b1;
        end
      end

      default: begin
      end
    endcase
  end

  // Sticky flags: a new error on the same cycle as clr_err wins.
  assign overflow_next  = set_overflow  | (overflow_reg  & ~clr_err);
  assign underflow_next = set_underflow | (underflow_reg & ~clr_err);
  assign proto_err_next = set_proto     | (proto_err_reg & ~clr_err);

  // ---------------------------------------------------------------------------
  // Datapath and flag registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp_reg        <= '0;
      pop_data_reg  <= '0;
      pop_valid_reg <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
      proto_err_reg <= 1'b0;
    end else begin
      sp_reg        <= sp_next;
      pop_valid_reg <= pop_valid_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
      proto_err_reg <= proto_err_next;
      // Capture only on the retiring edge; otherwise hold the last word.
      if (pop_valid_next) begin
        pop_data_reg <= ram_rdata;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign pop_data  = pop_data_reg;
  assign pop_valid = pop_valid_reg;
  assign busy      = (state_reg == ST_READ);
  assign full      = full_w;
  assign empty     = empty_w;
  assign sp        = sp_reg;
  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;
  assign proto_err = proto_err_reg;

endmodule : stack_unit

// File: tb/tb_stack_unit.sv
// -----------------------------------------------------------------------------
// tb_stack_unit
// Self-checking bench for stack_unit. A queue-based reference stack predicts
// every popped word; expected words are queued when a pop is issued and
// compared when pop_valid appears. Any pop_valid with nothing queued is
// reported as an error.
// -----------------------------------------------------------------------------
module tb_stack_unit;

  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int SPW   = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rst_n;
  logic             push_in;
  logic             pop_in;
  logic [WIDTH-1:0] push_data;
  logic             flush;
  logic             clr_err;
  logic [WIDTH-1:0] pop_data;
  logic             pop_valid;
  logic             busy;
  logic             full;
  logic             empty;
  logic [SPW-1:0]   sp;
  logic             overflow;
  logic             underflow;
  logic             proto_err;

  int vectors     = 0;
  int miscompares = 0;

  logic [WIDTH-1:0] model_stack [$];
  logic [WIDTH-1:0] exp_q       [$];

  stack_unit #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst_n),
    .push_in   (push_in),
    .pop_in    (pop_in),
    .push_data (push_data),
    .flush     (flush),
    .clr_err   (clr_err),
    .pop_data  (pop_data),
    .pop_valid (pop_valid),
    .busy      (busy),
    .full      (full),
    .empty     (empty),
    .sp        (sp),
    .overflow  (overflow),
    .underflow (underflow),
    .proto_err (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs,
                           input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // Scoreboard side: compare every pop_valid pulse against the queue.
  always @(negedge clk) begin
    if (pop_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_val("spurious_pop_valid", 64'd1, 64'd0);
      end else begin
        check_val("pop_data", 64'(pop_data), 64'(exp_q.pop_front()));
      end
    end
  end

  // Apply one cycle of inputs starting at a negedge; returns at the next
  // negedge, after the DUT has sampled them.
  task automatic step(input logic p, input logic q, input logic [WIDTH-1:0] d,
                      input logic f, input logic c);
    push_in   = p;
    pop_in    = q;
    push_data = d;
    flush     = f;
    clr_err   = c;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_push(input logic [WIDTH-1:0] d);
    if (model_stack.size() < DEPTH) model_stack.push_back(d);
    step(1'b1, 1'b0, d, 1'b0, 1'b0);
    check_val("sp_after_push", 64'(sp), 64'(model_stack.size()));
  endtask

  // Clean pop of a non-empty stack, with latency checks on the way.
  task automatic do_pop();
    exp_q.push_back(model_stack.pop_back());
    step(1'b0, 1'b1, '0, 1'b0, 1'b0);
    check_val("busy_in_read", 64'(busy), 64'd1);
    check_val("no_valid_early", 64'(pop_valid), 64'd0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    check_val("pop_valid_lat2", 64'(pop_valid), 64'd1);
    check_val("sp_after_pop", 64'(sp), 64'(model_stack.size()));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_sp"},        64'(sp),        64'd0);
    check_val({tag, "_empty"},     64'(empty),     64'd1);
    check_val({tag, "_full"},      64'(full),      64'd0);
    check_val({tag, "_busy"},      64'(busy),      64'd0);
    check_val({tag, "_pop_valid"}, 64'(pop_valid), 64'd0);
    check_val({tag, "_pop_data"},  64'(pop_data),  64'd0);
    check_val({tag, "_overflow"},  64'(overflow),  64'd0);
    check_val({tag, "_underflow"}, 64'(underflow), 64'd0);
    check_val({tag, "_proto_err"}, 64'(proto_err), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    push_in = 0; pop_in = 0; push_data = '0; flush = 0; clr_err = 0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    idle(1);

    // Basic LIFO order
    do_push(32'hA);
    do_push(32'hB);
    do_push(32'hC);
    check_val("sp_three", 64'(sp), 64'd3);
    do_pop();
    do_pop();

    // Flush in IDLE empties the stack
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    model_stack.delete();
    check_val("flush_idle_sp", 64'(sp), 64'd0);
    check_val("flush_idle_empty", 64'(empty), 64'd1);

    // Fill to full, overflow on the 17th push
    for (int i = 0; i < DEPTH; i++) do_push(WIDTH'(i));
    check_val("full_at_depth", 64'(full), 64'd1);
    do_push(32'hFF);
    check_val("overflow_set", 64'(overflow), 64'd1);
    check_val("sp_stays_depth", 64'(sp), 64'(DEPTH));
    for (int i = 0; i < DEPTH; i++) do_pop();
    check_val("empty_after_drain", 64'(empty), 64'd1);

    // Underflow, then clear
    step(1'b0, 1'b1, '0, 1'b0, 1'b0);
    idle(2);
    check_val("underflow_set", 64'(underflow), 64'd1);
    check_val("sp_no_wrap", 64'(sp), 64'd0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    check_val("underflow_clr", 64'(underflow), 64'd0);
    check_val("overflow_clr", 64'(overflow), 64'd0);
    // New error on the same cycle as clr_err keeps the flag set
    step(1'b0, 1'b1, '0, 1'b0, 1'b1);
    check_val("clr_vs_new_err", 64'(underflow), 64'd1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    idle(1);

    // Push and pop together
    do_push(32'h11);
    do_push(32'h22);
    step(1'b1, 1'b1, 32'h33, 1'b0, 1'b0);
    check_val("both_req_sp", 64'(sp), 64'd2);
    check_val("both_req_proto", 64'(proto_err), 64'd1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    check_val("proto_clr", 64'(proto_err), 64'd0);

    // pop_in held into READ: only one pop happens
    exp_q.push_back(model_stack.pop_back());
    step(1'b0, 1'b1, '0, 1'b0, 1'b0);
    step(1'b0, 1'b1, '0, 1'b0, 1'b0);
    check_val("read_req_valid", 64'(pop_valid), 64'd1);
    idle(2);
    check_val("read_req_proto", 64'(proto_err), 64'd1);
    check_val("read_req_sp", 64'(sp), 64'd1);

    // Reset in the middle of a pop read aborts it
    step(1'b0, 1'b1, '0, 1'b0, 1'b0);
    check_val("busy_before_rst", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid_read");
    model_stack.delete();
    @(negedge clk);
    idle(1);
    check_val("rst_mid_read_hold", 64'(pop_valid), 64'd0);
    rst_n = 1'b1;
    idle(2);

    // Flush during READ with 4 entries
    for (int i = 0; i < 4; i++) do_push(32'h100 + WIDTH'(i));
    exp_q.push_back(model_stack.pop_back());
    step(1'b0, 1'b1, '0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    model_stack.delete();
    check_val("flush_read_valid", 64'(pop_valid), 64'd1);
    check_val("flush_read_sp", 64'(sp), 64'd0);
    check_val("flush_read_empty", 64'(empty), 64'd1);

    // Flush beats a coincident push without raising an error
    do_push(32'h55);
    step(1'b1, 1'b0, 32'h66, 1'b1, 1'b0);
    model_stack.delete();
    check_val("flush_push_sp", 64'(sp), 64'd0);
    check_val("flush_push_proto", 64'(proto_err), 64'd0);
    check_val("flush_push_ovf", 64'(overflow), 64'd0);
    idle(3);

    check_val("pending_pops", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_stack_unit

// File: doc/stack_unit.md
STACK_UNIT -- requirements
Module: stack_unit

Interface
REQ-001 SHALL have parameter WIDTH, 32, data word width in bits.
REQ-002 SHALL have parameter DEPTH, 16, number of stack entries (power of two, 2..64).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port push_in  input  1  one-cycle push request, driven by the decode stage push_out.
REQ-006 SHALL have port pop_in  input  1  one-cycle pop request, driven by the decode stage pop_out.
REQ-007 SHALL have port push_data  input  WIDTH  word to push (readData2 of decode).
REQ-008 SHALL have port flush  input  1  empty the stack (sp to 0).
REQ-009 SHALL have port clr_err  input  1  clear sticky error flags.
REQ-010 SHALL have port pop_data  output  WIDTH  popped word, valid while pop_valid is high.
REQ-011 SHALL have port pop_valid  output  1  one-cycle pulse marking pop_data valid.
REQ-012 SHALL have port busy  output  1  high while a pop read is in flight.
REQ-013 SHALL have port full, empty  output  1 each  sp==DEPTH, sp==0.
REQ-014 SHALL have port sp  output  log2(DEPTH)+1  current entry count.
REQ-015 SHALL have port overflow, underflow, proto_err  output  1 each  sticky error flags.

Function
REQ-016 SHALL use two-state FSM: IDLE, READ.
REQ-017 In IDLE, push_in alone and not full: mem[sp] <= push_data, sp <= sp+1, remain IDLE (1-cycle push).
REQ-018 In IDLE, pop_in alone and not empty: sp <= sp-1, RAM read of address sp-1 launched, go to READ.
REQ-019 In READ: pop_data <= RAM output, pop_valid = 1 for exactly that one cycle, busy = 1, return to IDLE.
REQ-020 Pop latency SHALL be 2 cycles: request at edge N, pop_valid high in the cycle after edge N+1.
REQ-021 pop_data SHALL hold its last value when pop_valid is low.
REQ-022 Push while full SHALL be dropped, sp unchanged, overflow set.
REQ-023 Pop while empty SHALL be dropped, no READ, no pop_valid, underflow set.
REQ-024 push_in and pop_in both high in IDLE SHALL perform neither operation and set proto_err.
REQ-025 Any push_in or pop_in while in READ SHALL be dropped and set proto_err.
REQ-026 flush in IDLE SHALL set sp to 0; flush in READ SHALL let the pending pop complete, then sp = 0; flush has priority over a coincident push/pop, which is dropped without error.
REQ-027 Sticky flags SHALL stay set until clr_err or reset; clr_err coincident with a new error leaves the flag set.
REQ-028 Pointer arithmetic SHALL never wrap: sp stays in 0..DEPTH.
REQ-029 full/empty SHALL be combinational from sp; all other outputs registered.

Reset
REQ-030 On rst low: state IDLE, sp 0, pop_data 0, pop_valid 0, all error flags 0; empty 1, full 0, busy 0.
REQ-031 Reset mid-READ SHALL abort the pop with no pop_valid pulse.
REQ-032 RAM contents SHALL NOT be reset and are not observable after reset until written.

Structure
REQ-033 Shared package musa_pkg SHALL hold WORD_WIDTH (32), STACK_DEPTH (16) and the FSM state encoding.
REQ-034 Storage SHALL be a sub-module stack_ram: synchronous write, synchronous 1-cycle read, one write and one read port.

Verification
REQ-035 Reset, push 0xA, 0xB, 0xC -> sp 3; pop -> pop_data 0xC two cycles later, sp 2; pop -> 0xB.
REQ-036 Push 16 words 0..15 -> full 1; 17th push 0xFF -> overflow 1, sp 16; 16 pops return 15..0, empty 1.
REQ-037 Pop on empty -> no pop_valid, underflow 1; clr_err -> underflow 0.
REQ-038 push_in and pop_in together with sp 2 -> sp 2, proto_err 1; pop_in during READ -> proto_err 1, only one pop_valid.
REQ-039 Pop issued, rst low during READ -> no pop_valid, sp 0, all outputs at reset values.
REQ-040 flush during READ with sp 4 -> pending pop returns top word, then sp 0, empty 1.
